vpg_fetch_ctrl: RTL and testbench
=================================

Name: vpg_fetch_ctrl

Overview:
Read scheduler that keeps the video pattern generator's pixel FIFO fed from frame memory. It restarts a frame fetch on every framestart pulse from the generator and issues fixed-length burst read requests to the memory port. It throttles on FIFO space, tracked as credits, decremented by the generator's readreq (one pixel per cycle of DE) and by reservations made when bursts are accepted. It also detects and flags underflow. It sits between the frame memory arbiter and the external pixel FIFO whose output drives i_rgb.

Parameters:
H_ACTIVE, 1024, active pixels per line
V_ACTIVE, 768, active lines per frame
BURST_LEN, 32, words per burst; H_ACTIVE*V_ACTIVE must be a multiple of it (elaboration check)
FIFO_DEPTH, 256, pixel FIFO depth in words; must be >= BURST_LEN
MAX_OUTST, 4, max accepted-but-incomplete bursts
ADDR_W, 25, word address width

Ports:
vgaclk  in  1  pixel clock, all logic rising-edge
reset  in  1  asynchronous, active-high
framestart  in  1  one-cycle pulse from generator at frame start
readreq  in  1  pixel popped from FIFO this cycle
frame_base  in  ADDR_W  frame buffer base; sampled only on framestart
mem_req  out  1  burst read request
mem_addr  out  ADDR_W  burst start word address, stable while mem_req=1
mem_ack  in  1  request accepted this cycle (valid only with mem_req=1)
mem_rvalid  in  1  one returned data word this cycle
fifo_wr  out  1  write returned word into FIFO (combinational: mem_rvalid & ~discard)
fifo_clr  out  1  one-cycle synchronous FIFO flush
underflow  out  1  sticky; readreq seen with no data in FIFO
frame_done  out  1  one-cycle pulse when the last burst of a frame is accepted

Behaviour:
- Reset values: mem_req=0, mem_addr=0, fifo_clr=0, underflow=0, frame_done=0, discard=0, all counters 0, state=IDLE.
- Counters:
  - words_left (20 b): words not yet requested in the current frame.
  - credit (log2(FIFO_DEPTH)+1 b): reserved plus occupied FIFO words. +BURST_LEN on accept, -1 on readreq.
  - avail (same width): words present in the FIFO. +1 on fifo_wr, -1 on readreq when avail>0.
  - inflight: words accepted but not yet returned. +BURST_LEN on accept, -1 on mem_rvalid.
  - outst: bursts outstanding, derived as ceil(inflight/BURST_LEN) or tracked directly.
  - All counters use net update when increment and decrement events fall in the same cycle. No saturation is needed except credit/avail, which never go below 0.
- States:
  - IDLE: wait for framestart.
  - DRAIN: framestart arrived with inflight>0. Assert discard, hold mem_req=0, and wait for inflight==0.
  - START: one cycle. fifo_clr=1; credit=avail=0; words_left=H_ACTIVE*V_ACTIVE; mem_addr=latched frame_base.
  - FETCH: assert mem_req when credit+BURST_LEN<=FIFO_DEPTH, outst<MAX_OUTST and words_left>0.
    - Once asserted, hold mem_req and mem_addr until mem_ack, even if readreq changes credit.
    - On ack: mem_addr+=BURST_LEN, words_left-=BURST_LEN, and mem_req drops for at least one cycle.
    - When words_left reaches 0 on ack: pulse frame_done and go to DONE.
  - DONE: wait for framestart.
- framestart handling:
  - From IDLE/DONE/FETCH: latch frame_base. Go to START if inflight==0 (after a pending ack is counted), else DRAIN. Any held mem_req is withdrawn the same cycle unless it is acked that cycle.
  - From DRAIN: relatch frame_base and stay in DRAIN.
- Latency: with no inflight, framestart at cycle T gives fifo_clr at T+1 and mem_req at T+2 with mem_addr=frame_base.
- discard: set on entry to DRAIN, cleared on entry to START. Returned words while discard=1 decrement inflight but do not touch avail/fifo_wr.
- Underflow: readreq with avail==0 sets underflow. It stays set until reset; credit and avail are not decremented on that event.
- Address wraps modulo 2^ADDR_W; no other boundary checks.
- Reset mid-burst: all state clears immediately. Returned words after reset are not counted; the system must reset memory together with this block.

Decomposition:
- Shared package vpg_pkg:
  - video constants H_ACTIVE/V_ACTIVE (1024x768, matching the generator's timing set);
  - fetch state enum {IDLE, DRAIN, START, FETCH, DONE};
  - the BURST_LEN default.
- One natural sub-module: vpg_credit_cnt, the up-by-N/down-by-1 counter with net-update and floor-at-zero, instantiated for credit, avail and inflight.

Test Plan:
- Reset, then framestart with frame_base=0x100000 -> fifo_clr at T+1; mem_req at T+2 with mem_addr=0x100000. After ack, next mem_addr=0x100020.
- Ack every request immediately, never readreq, FIFO_DEPTH=256 -> exactly 8 bursts accepted, then mem_req stays 0. One readreq -> still 0. 32 readreqs -> mem_req reasserts next cycle.
- Return data 10 cycles late with MAX_OUTST=4 -> never more than 4 bursts outstanding. fifo_wr mirrors mem_rvalid.
- Full frame of 786432 words -> 24576 acks, frame_done pulses once on the last ack, state DONE, no further mem_req.
- framestart while 2 bursts (64 words) are inflight -> discard=1, fifo_wr=0 for those 64 words. Then fifo_clr, then mem_req with the new frame_base.
- readreq on the first cycle after START (avail=0) -> underflow=1 and stays set through the next framestart. Counters are not decremented below 0.

Source files
------------

// File: rtl/vpg_pkg.sv
// Shared constants and types for the video pattern generator fetch path.
package vpg_pkg;

  // Active video size, matching the generator's 1024x768 timing set.
  localparam int unsigned VID_H_ACTIVE = 1024;
  localparam int unsigned VID_V_ACTIVE = 768;

  // Default memory burst length in words.
  localparam int unsigned BURST_LEN_DEF = 32;

  // Width of the per-frame words-left counter (holds 1024*768).
  localparam int unsigned WORDS_LEFT_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    START,
    FETCH,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/vpg_credit_cnt.sv
// Up-by-STEP / down-by-1 counter with net update, floor at zero and sync clear.
module vpg_credit_cnt #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned STEP  = 32
) (
  input  logic             vgaclk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] StepV = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] OneV  = WIDTH'(1);

  logic [WIDTH-1:0] raised;
  logic [WIDTH-1:0] count_d;

  // Apply the increment first so a same-cycle inc/dec at zero still nets out.
  always_comb begin
    raised  = count + (inc ? StepV : '0);
    count_d = raised;
    if (dec && (raised != '0)) begin
      count_d = raised - OneV;
    end
    if (clr) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/vpg_fetch_ctrl.sv
// Frame read scheduler: keeps the pixel FIFO fed with burst reads from frame memory.
module vpg_fetch_ctrl
  import vpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VID_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = VID_V_ACTIVE,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned ADDR_W     = 25
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic              framestart,
  input  logic              readreq,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  output logic              fifo_wr,
  output logic              fifo_clr,
  output logic              underflow,
  output logic              frame_done
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned InflW = $clog2(MAX_OUTST * BURST_LEN + 1);

  localparam logic [WORDS_LEFT_W-1:0] FrameWords = WORDS_LEFT_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [WORDS_LEFT_W-1:0] BurstWords = WORDS_LEFT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]       AddrStep   = ADDR_W'(BURST_LEN);
  localparam logic [CntW-1:0]         CreditMax  = CntW'(FIFO_DEPTH - BURST_LEN);
  // ceil(inflight/BURST_LEN) < MAX_OUTST  <=>  inflight <= (MAX_OUTST-1)*BURST_LEN
  localparam logic [InflW-1:0]        InflMax    = InflW'((MAX_OUTST - 1) * BURST_LEN);
  localparam logic [InflW-1:0]        InflOne    = InflW'(1);

  if ((H_ACTIVE * V_ACTIVE) % BURST_LEN != 0) begin : g_bad_frame
    $error("vpg_fetch_ctrl: frame size must be a multiple of BURST_LEN");
  end
  if (FIFO_DEPTH < BURST_LEN) begin : g_bad_depth
    $error("vpg_fetch_ctrl: FIFO_DEPTH must be >= BURST_LEN");
  end

  fetch_state_e            state;
  logic [ADDR_W-1:0]       base;
  logic [WORDS_LEFT_W-1:0] words_left;
  logic                    discard;

  logic [CntW-1:0]  credit;
  logic [CntW-1:0]  avail;
  logic [InflW-1:0] inflight;

  logic ack_fire;
  logic pop;
  logic clr_cnt;
  logic can_issue;
  logic infl_zero_next;

  assign ack_fire  = mem_req & mem_ack;
  // A pop with an empty FIFO is an underflow and consumes nothing.
  assign pop       = readreq & (avail != '0);
  assign clr_cnt   = (state == START);
  assign fifo_wr   = mem_rvalid & ~discard;
  assign can_issue = (credit <= CreditMax) && (inflight <= InflMax) && (words_left != '0);
  // inflight will be zero after this edge, counting any ack landing now.
  assign infl_zero_next = ~ack_fire & ((inflight == '0) | ((inflight == InflOne) & mem_rvalid));

  vpg_credit_cnt #(.WIDTH(CntW), .STEP(BURST_LEN)) u_credit (
    .vgaclk (vgaclk),
    .reset  (reset),
    .clr    (clr_cnt),
    .inc    (ack_fire),
    .dec    (pop),
    .count  (credit)
  );

  vpg_credit_cnt #(.WIDTH(CntW), .STEP(1)) u_avail (
    .vgaclk (vgaclk),
    .reset  (reset),
    .clr    (clr_cnt),
    .inc    (fifo_wr),
    .dec    (pop),
    .count  (avail)
  );

  vpg_credit_cnt #(.WIDTH(InflW), .STEP(BURST_LEN)) u_inflight (
    .vgaclk (vgaclk),
    .reset  (reset),
    .clr    (1'b0),
    .inc    (ack_fire),
    .dec    (mem_rvalid),
    .count  (inflight)
  );

  // Fetch FSM with registered request, address and status outputs.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      words_left <= '0;
      discard    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fifo_clr   <= 1'b0;
      underflow  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_clr   <= 1'b0;
      frame_done <= 1'b0;

      if (readreq && (avail == '0)) begin
        underflow <= 1'b1;
      end

      // An accepted burst always advances, even if framestart lands the same cycle.
      if (ack_fire) begin
        mem_req    <= 1'b0;
        mem_addr   <= mem_addr + AddrStep;
        words_left <= words_left - BurstWords;
        if (words_left == BurstWords) begin
          frame_done <= 1'b1;
          state      <= DONE;
        end
      end

      unique case (state)
        IDLE, DONE, FETCH: begin
          if (framestart) begin
            base    <= frame_base;
            mem_req <= 1'b0;
            if (infl_zero_next) begin
              state    <= START;
              fifo_clr <= 1'b1;
              discard  <= 1'b0;
            end else begin
              state   <= DRAIN;
              discard <= 1'b1;
            end
          end else if ((state == FETCH) && !mem_req && can_issue) begin
            mem_req <= 1'b1;
          end
        end
        DRAIN: begin
          if (framestart) begin
            base <= frame_base;
          end else if (inflight == '0) begin
            state    <= START;
            fifo_clr <= 1'b1;
            discard  <= 1'b0;
          end
        end
        START: begin
          // Counters are empty after this edge, so the first burst is always allowed.
          state      <= FETCH;
          mem_req    <= 1'b1;
          mem_addr   <= base;
          words_left <= FrameWords;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpg_fetch_ctrl.sv
// Self-checking bench for vpg_fetch_ctrl: randomized memory/reader with a behavioural model.
module tb_vpg_fetch_ctrl;

  localparam int H     = 64;
  localparam int V     = 16;
  localparam int B     = 32;
  localparam int D     = 256;
  localparam int MO    = 4;
  localparam int AW    = 25;
  localparam int AMASK = (1 << AW) - 1;

  localparam int S_IDLE  = 0;
  localparam int S_DRAIN = 1;
  localparam int S_START = 2;
  localparam int S_FETCH = 3;
  localparam int S_DONE  = 4;

  logic          vgaclk     = 1'b0;
  logic          reset      = 1'b1;
  logic          framestart = 1'b0;
  logic          readreq    = 1'b0;
  logic          mem_ack    = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          fifo_wr;
  logic          fifo_clr;
  logic          underflow;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  vpg_fetch_ctrl #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .BURST_LEN  (B),
    .FIFO_DEPTH (D),
    .MAX_OUTST  (MO),
    .ADDR_W     (AW)
  ) dut (
    .vgaclk     (vgaclk),
    .reset      (reset),
    .framestart (framestart),
    .readreq    (readreq),
    .frame_base (frame_base),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .fifo_wr    (fifo_wr),
    .fifo_clr   (fifo_clr),
    .underflow  (underflow),
    .frame_done (frame_done)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (plain integers) ----------------
  int m_state, m_req, m_addr, m_base, m_left, m_cred, m_avail, m_infl;
  int m_discard, m_under, m_clr, m_done;
  int t_ack, t_wr, t_pop, t_issue, n_infl, n_cred, n_avail, n_req, n_state;

  always @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      m_state = S_IDLE; m_req = 0; m_addr = 0; m_base = 0; m_left = 0;
      m_cred = 0; m_avail = 0; m_infl = 0; m_discard = 0; m_under = 0;
      m_clr = 0; m_done = 0;
    end else begin
      t_ack = (m_req != 0 && mem_ack) ? 1 : 0;
      t_wr  = (mem_rvalid && m_discard == 0) ? 1 : 0;
      t_pop = (readreq && m_avail > 0) ? 1 : 0;
      t_issue = (m_state == S_FETCH && m_req == 0 && m_cred + B <= D &&
                 (m_infl + B - 1) / B < MO && m_left > 0) ? 1 : 0;
      n_infl  = m_infl + t_ack * B - (mem_rvalid ? 1 : 0);
      if (n_infl < 0) n_infl = 0;
      n_cred  = m_cred + t_ack * B - t_pop;
      if (n_cred < 0) n_cred = 0;
      n_avail = m_avail + t_wr - t_pop;
      if (n_avail < 0) n_avail = 0;
      if (readreq && m_avail == 0) m_under = 1;
      m_clr = 0;
      m_done = 0;
      n_req = m_req;
      n_state = m_state;
      if (t_ack != 0) begin
        n_req = 0;
        m_addr = (m_addr + B) & AMASK;
        m_left = m_left - B;
        if (m_left == 0) begin
          m_done = 1;
          n_state = S_DONE;
        end
      end
      case (m_state)
        S_IDLE, S_DONE, S_FETCH: begin
          if (framestart) begin
            m_base = int'(frame_base);
            n_req = 0;
            if (n_infl == 0) begin
              n_state = S_START; m_clr = 1; m_discard = 0;
            end else begin
              n_state = S_DRAIN; m_discard = 1;
            end
          end else if (t_issue != 0) begin
            n_req = 1;
          end
        end
        S_DRAIN: begin
          if (framestart) m_base = int'(frame_base);
          else if (m_infl == 0) begin
            n_state = S_START; m_clr = 1; m_discard = 0;
          end
        end
        S_START: begin
          n_state = S_FETCH; n_req = 1; m_addr = m_base; m_left = H * V;
          n_cred = 0; n_avail = 0;
        end
        default: ;
      endcase
      m_state = n_state; m_req = n_req;
      m_infl = n_infl; m_cred = n_cred; m_avail = n_avail;
    end
  end

  // ---------------- memory and reader stimulus ----------------
  int cyc = 0, acks = 0, frame_acks = 0;
  int ack_budget = 1000000, lat = 2, ret_en = 1, ack_rand = 0, rd_mode = 0, rd_pulses = 0;
  int rdy_q[$];
  int left_q[$];

  always @(posedge vgaclk) begin
    cyc++;
    if (!reset && mem_req && mem_ack) begin
      acks++;
      frame_acks++;
      if (ack_budget > 0) ack_budget--;
      rdy_q.push_back(cyc + lat);
      left_q.push_back(B);
    end
    #1;
    mem_ack = mem_req && (ack_budget > 0) && (ack_rand == 0 || $urandom_range(0, 1) == 1);
    mem_rvalid = 1'b0;
    if (ret_en != 0 && rdy_q.size() > 0 && rdy_q[0] <= cyc) begin
      mem_rvalid = 1'b1;
      left_q[0] = left_q[0] - 1;
      if (left_q[0] == 0) begin
        void'(rdy_q.pop_front());
        void'(left_q.pop_front());
      end
    end
    if (rd_pulses > 0) begin
      readreq = 1'b1;
      rd_pulses--;
    end else if (rd_mode == 1) begin
      readreq = (m_avail > 0) && ($urandom_range(0, 1) == 1);
    end else begin
      readreq = 1'b0;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  int done_cnt = 0, rv_cnt = 0, wr_cnt = 0, max_outst = 0;

  always @(negedge vgaclk) begin
    if (!reset) begin
      chk("mem_req", mem_req, m_req);
      chk("mem_addr", mem_addr, m_addr);
      chk("fifo_clr", fifo_clr, m_clr);
      chk("underflow", underflow, m_under);
      chk("frame_done", frame_done, m_done);
      chk("fifo_wr", fifo_wr, (mem_rvalid && m_discard == 0) ? 1 : 0);
      if (frame_done) done_cnt++;
      if (mem_rvalid) rv_cnt++;
      if (fifo_wr) wr_cnt++;
      if (rdy_q.size() > max_outst) max_outst = rdy_q.size();
    end
  end

  // ---------------- directed sequence with literal expectations ----------------
  initial begin
    int n;
    int a0;
    repeat (3) @(negedge vgaclk);
    reset = 1'b0;
    @(negedge vgaclk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fifo_clr", fifo_clr, 0);
    chk("rst_underflow", underflow, 0);

    // Start latency and address step.
    frame_base = 25'h100000;
    framestart = 1'b1;
    frame_acks = 0;
    @(negedge vgaclk);
    framestart = 1'b0;
    chk("lat_fifo_clr", fifo_clr, 1);
    chk("lat_req_low", mem_req, 0);
    @(negedge vgaclk);
    chk("lat_req", mem_req, 1);
    chk("lat_addr", mem_addr, 'h100000);
    @(negedge vgaclk);
    chk("next_addr", mem_addr, 'h100020);

    // FIFO space limits bursts to D/B with nothing read.
    repeat (400) @(negedge vgaclk);
    chk("credit_bursts", acks, 8);
    chk("credit_stall", mem_req, 0);
    rd_pulses = 1;
    repeat (6) @(negedge vgaclk);
    chk("one_pop_acks", acks, 8);
    chk("one_pop_stall", mem_req, 0);
    rd_pulses = 31;
    repeat (40) @(negedge vgaclk);
    chk("refill_acks", acks, 9);

    // Random acks, late returns and random reads until the frame completes.
    lat = 10;
    ack_rand = 1;
    rd_mode = 1;
    n = 0;
    while (done_cnt == 0 && n < 30000) begin
      @(negedge vgaclk);
      n++;
    end
    chk("frame_done_seen", done_cnt, 1);
    chk("frame_acks", frame_acks, H * V / B);
    rd_mode = 0;
    a0 = acks;
    repeat (30) @(negedge vgaclk);
    chk("done_no_acks", acks, a0);
    chk("done_req_low", mem_req, 0);
    chk("done_pulse_once", done_cnt, 1);

    // Let all returns finish, then hold two bursts in flight across a framestart.
    n = 0;
    while (rdy_q.size() > 0 && n < 2000) begin
      @(negedge vgaclk);
      n++;
    end
    chk("returns_drained", rdy_q.size(), 0);
    ret_en = 0;
    ack_rand = 0;
    ack_budget = 2;
    lat = 1;
    frame_base = 25'h0200040;
    framestart = 1'b1;
    frame_acks = 0;
    @(negedge vgaclk);
    framestart = 1'b0;
    n = 0;
    while (frame_acks < 2 && n < 100) begin
      @(negedge vgaclk);
      n++;
    end
    chk("two_acks", frame_acks, 2);
    repeat (3) @(negedge vgaclk);
    rv_cnt = 0;
    wr_cnt = 0;
    frame_base = 25'h1FFFFE0;
    framestart = 1'b1;
    ack_budget = 1000000;
    @(negedge vgaclk);
    framestart = 1'b0;
    ret_en = 1;
    n = 0;
    while (!fifo_clr && n < 500) begin
      @(negedge vgaclk);
      n++;
    end
    chk("drain_clr_seen", fifo_clr, 1);
    chk("drain_rvalid", rv_cnt, 64);
    chk("drain_no_wr", wr_cnt, 0);

    // Read from an empty FIFO on the first fetch cycle; address wraps.
    rd_pulses = 1;
    @(negedge vgaclk);
    chk("new_req", mem_req, 1);
    chk("new_addr", mem_addr, 'h1FFFFE0);
    @(negedge vgaclk);
    chk("underflow_set", underflow, 1);
    chk("wrap_addr", mem_addr, 0);
    frame_base = '0;
    framestart = 1'b1;
    @(negedge vgaclk);
    framestart = 1'b0;
    repeat (5) @(negedge vgaclk);
    chk("underflow_sticky", underflow, 1);
    chk("max_outst_le4", (max_outst <= MO) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
